// File: rtl/cla_seq_wide_adder.sv
// rtl/cla_seq_wide_adder.sv - multi-cycle wide adder, one CHUNK_WIDTH carry-lookahead slice per cycle
// Carry is registered between chunks so only one narrow CLA is built regardless of DATA_WIDTH.

module cla_parametric #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W-1:0] w_g;
  logic [W-1:0] w_p;
  logic [W:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < W; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
  end

  assign sum  = w_p ^ w_c[W-1:0];
  assign cout = w_c[W];
endmodule

module cla_seq_wide_adder #(
  parameter int DATA_WIDTH  = 128,
  parameter int CHUNK_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  busy
);
  localparam int NUM_CHUNKS = (DATA_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int W_LAST     = DATA_WIDTH - (NUM_CHUNKS - 1) * CHUNK_WIDTH;
  localparam int PAD_W      = NUM_CHUNKS * CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_carry;
  logic [PAD_W-1:0]        r_op_a;
  logic [PAD_W-1:0]        r_op_b;
  logic [DATA_WIDTH-1:0]   r_sum;
  logic                    r_cout;

  logic                    w_accept;
  int                      w_base;
  logic [CHUNK_WIDTH-1:0]  w_chunk_a;
  logic [CHUNK_WIDTH-1:0]  w_chunk_b;
  logic [CHUNK_WIDTH-1:0]  w_add_sum;
  logic                    w_add_cout;
  logic                    w_top_cout;

  assign w_accept  = in_valid && in_ready;
  assign w_base    = int'(r_idx) * CHUNK_WIDTH;
  // Operand registers are zero-padded to a whole number of chunks, so the top slice is padded for free.
  assign w_chunk_a = r_op_a[w_base +: CHUNK_WIDTH];
  assign w_chunk_b = r_op_b[w_base +: CHUNK_WIDTH];

  cla_parametric #(.W(CHUNK_WIDTH)) u_cla (
    .a    (w_chunk_a),
    .b    (w_chunk_b),
    .cin  (r_carry),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  generate
    if (W_LAST < CHUNK_WIDTH) begin : g_short_top
      assign w_top_cout = w_add_sum[W_LAST];
    end else begin : g_full_top
      assign w_top_cout = w_add_cout;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) w_next = S_ADD;
      end
      S_ADD: begin
        busy = 1'b1;
        if (r_idx == LAST_IDX) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_op_a  <= PAD_W'(a);
      r_op_b  <= PAD_W'(b);
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == S_ADD) begin
      for (int j = 0; j < CHUNK_WIDTH; j++) begin
        if (w_base + j < DATA_WIDTH) r_sum[w_base + j] <= w_add_sum[j];
      end
      r_carry <= w_add_cout;
      if (r_idx == LAST_IDX) begin
        r_cout <= w_top_cout;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
endmodule
